piso_shift_ctrl: RTL and testbench

Parallel-in/serial-out word shifter with handshake, built from WIDTH load/shift mux-flop stages. It sits upstream of the serial consumer and downstream of a parallel word producer. It accepts one WIDTH-bit word, then emits it one bit per cycle under a valid/ready handshake. It exposes the per-stage load select as L so the mux-flop chain can be probed directly.

---
 rtl/piso_shift_ctrl_if.sv | 24 ++
 rtl/piso_shift_ctrl.sv | 91 +++++++++
 tb/tb_piso_shift_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/piso_shift_ctrl_if.sv
// Handshake bundle for piso_shift_ctrl: parallel word input side and serial bit output side.
interface piso_shift_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             L;
    logic             ser_ready;
    logic             ser_valid;
    logic             ser_out;
    logic             ser_last;
    logic             busy;

    modport master (
        output in_valid, in_data, ser_ready,
        input  in_ready, L, ser_valid, ser_out, ser_last, busy
    );

    modport slave (
        input  in_valid, in_data, ser_ready,
        output in_ready, L, ser_valid, ser_out, ser_last, busy
    );
endinterface

// File: rtl/piso_shift_ctrl.sv
// Parallel-in/serial-out word shifter with valid/ready on both sides.
// Define PISO_LSB_FIRST_EN to emit LSB first; default build is MSB first.
module piso_shift_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    piso_shift_ctrl_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [CNT_W-1:0] cnt;

    logic             last_slot;
    logic             in_ready_c;
    logic             accept_c;
    logic             ser_bit_c;
    logic [WIDTH-1:0] sreg_shifted_c;

    assign last_slot = (state == SHIFT) && (cnt == '0);

    // A new word may enter when idle, or in the slot where the final bit is consumed.
    always_comb begin
        in_ready_c = 1'b0;
        if (!reset) begin
            if (state == IDLE) begin
                in_ready_c = 1'b1;
            end else begin
                in_ready_c = bus.ser_ready && last_slot;
            end
        end
    end

    assign accept_c = bus.in_valid && in_ready_c;

`ifdef PISO_LSB_FIRST_EN
    assign ser_bit_c      = sreg[0];
    assign sreg_shifted_c = sreg >> 1;
`else
    assign ser_bit_c      = sreg[WIDTH-1];
    assign sreg_shifted_c = sreg << 1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        sreg  <= bus.in_data;
                        cnt   <= CNT_W'(WIDTH - 1);
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bus.ser_ready) begin
                        if (cnt != '0) begin
                            sreg <= sreg_shifted_c;
                            cnt  <= cnt - CNT_W'(1);
                        end else if (accept_c) begin
                            // Back-to-back reload: no idle bubble between words.
                            sreg <= bus.in_data;
                            cnt  <= CNT_W'(WIDTH - 1);
                        end else begin
                            sreg  <= '0;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.L         = accept_c;
    assign bus.ser_valid = (state == SHIFT);
    assign bus.busy      = (state == SHIFT);
    assign bus.ser_out   = (state == SHIFT) && ser_bit_c;
    assign bus.ser_last  = last_slot;
endmodule

// File: tb/tb_piso_shift_ctrl.sv
// Scoreboard bench for piso_shift_ctrl: directed scenarios followed by random traffic.
// Honors PISO_LSB_FIRST_EN for the expected bit order.
module tb_piso_shift_ctrl;
    localparam int unsigned WIDTH = 8;

    typedef struct {
        bit b;
        bit last;
    } exp_bit_t;

    logic clk;
    logic reset;

    piso_shift_ctrl_if #(.WIDTH(WIDTH)) bus ();

    piso_shift_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    exp_bit_t sb[$];
    int       remaining = 0;
    int       run       = 0;
    int       last_run  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks bits left in the current word and predicts the handshake.
    always @(negedge clk) begin
        bit pred_ready;
        bit pred_acc;
        pred_ready = (reset == 1'b0) && ((remaining == 0) || (bus.ser_ready && remaining == 1));
        pred_acc   = bus.in_valid && pred_ready;
        chk("in_ready", 32'(bus.in_ready), 32'(pred_ready));
        chk("L", 32'(bus.L), 32'(pred_acc));
        chk("busy", 32'(bus.busy), 32'(remaining > 0));
        chk("ser_valid", 32'(bus.ser_valid), 32'(remaining > 0));
        if (remaining == 0) begin
            chk("idle_ser_out", 32'(bus.ser_out), 32'd0);
            chk("idle_ser_last", 32'(bus.ser_last), 32'd0);
        end
        if (reset) begin
            remaining = 0;
            sb.delete();
        end else begin
            if (remaining > 0 && bus.ser_ready) remaining--;
            if (pred_acc) begin
                logic [WIDTH-1:0] d;
                d = bus.in_data;
                for (int i = 0; i < int'(WIDTH); i++) begin
                    exp_bit_t e;
`ifdef PISO_LSB_FIRST_EN
                    e.b = d[i];
`else
                    e.b = d[WIDTH-1-i];
`endif
                    e.last = (i == int'(WIDTH) - 1);
                    sb.push_back(e);
                end
                remaining = WIDTH;
            end
        end
    end

    // Monitor: compares presented bits against the scoreboard, popping on each transfer.
    always @(negedge clk) begin
        if (bus.ser_valid && !reset) begin
            run++;
            if (sb.size() == 0) begin
                chk("unexpected_bit", 32'(bus.ser_valid), 32'd0);
            end else begin
                chk("ser_out", 32'(bus.ser_out), 32'(sb[0].b));
                chk("ser_last", 32'(bus.ser_last), 32'(sb[0].last));
                if (bus.ser_ready) void'(sb.pop_front());
            end
        end else if (run > 0) begin
            last_run = run;
            run      = 0;
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Hold in_valid with d until accepted; leaves in_valid high on return.
    task automatic offer(input logic [WIDTH-1:0] d, output bit acc_in_last);
        bit done;
        done        = 1'b0;
        acc_in_last = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (bus.L) begin
                done        = 1'b1;
                acc_in_last = bus.ser_last;
            end
            cycle();
        end
        if (!done) chk("offer_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        bit lflag;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.ser_ready = 1'b1;
        repeat (2) cycle();
        reset = 1'b0;
        cycle();

        // Single word, continuous ser_ready.
        offer(8'hA5, lflag);
        bus.in_valid = 1'b0;
        repeat (12) cycle();
        chk("basic_run_len", 32'(last_run), 32'd8);

        // Back-to-back words with in_valid held.
        offer(8'hC1, lflag);
        offer(8'h3C, lflag);
        bus.in_valid = 1'b0;
        chk("b2b_accept_in_last", 32'(lflag), 32'd1);
        repeat (20) cycle();
        chk("b2b_run_len", 32'(last_run), 32'd16);

        // Three-cycle stall starting at bit index 2.
        offer(8'hC1, lflag);
        bus.in_valid = 1'b0;
        repeat (2) cycle();
        bus.ser_ready = 1'b0;
        repeat (3) cycle();
        bus.ser_ready = 1'b1;
        repeat (12) cycle();
        chk("stall_run_len", 32'(last_run), 32'd11);

        // in_valid while busy (bit index 3) must be ignored.
        offer(8'hC1, lflag);
        bus.in_valid = 1'b0;
        repeat (3) cycle();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hFF;
        cycle();
        bus.in_valid = 1'b0;
        repeat (10) cycle();
        chk("reject_run_len", 32'(last_run), 32'd8);

        // Reset at bit index 4.
        offer(8'hA5, lflag);
        bus.in_valid = 1'b0;
        repeat (4) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ser_valid", 32'(bus.ser_valid), 32'd0);
        chk("rst_ser_out", 32'(bus.ser_out), 32'd0);
        chk("rst_ser_last", 32'(bus.ser_last), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        cycle();
        repeat (3) cycle();

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 1500; n++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_data   = WIDTH'($urandom);
            bus.ser_ready = ($urandom_range(0, 3) != 0);
            reset         = ($urandom_range(0, 99) == 0);
            cycle();
        end
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.ser_ready = 1'b1;
        repeat (20) cycle();
        chk("drain_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
